// File: rtl/idex_pipe_stage_pkg.sv
// ---------------------------------------------------------------------------
// idex_pipe_stage_pkg
// Shared definitions for the decode->execute pipeline register and the generic
// skid buffer it is built on. Holds the default control-word width, the bit
// position of each field inside the packed control word, the buffer state
// encoding and a helper that computes the packed payload width.
// ---------------------------------------------------------------------------
package idex_pipe_stage_pkg;

   // Default width of the packed control word
   // {RegWrite,MemtoReg,MemWrite,ALUControl[2:0],ALUSrc,RegDst}.
   localparam int CTRL_W_DEF = 8;

   // Bit positions of the individual control fields inside the control word.
   // Downstream stages use these instead of magic numbers.
   localparam int CTRL_REGWRITE   = 7;
   localparam int CTRL_MEMTOREG   = 6;
   localparam int CTRL_MEMWRITE   = 5;
   localparam int CTRL_ALUCTRL_HI = 4;
   localparam int CTRL_ALUCTRL_LO = 2;
   localparam int CTRL_ALUSRC     = 1;
   localparam int CTRL_REGDST     = 0;

   // Occupancy of the two-entry buffer: nothing held, only the main entry
   // held, or main plus the skid entry held.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } skidState_t;

   // Width of the packed payload {Ctrl,Rd1,Rd2,Rs,Rt,Rd,SignImm}.
   function automatic int payloadWidth(input int ctrlW, input int wordW, input int regAw);
      return ctrlW + 3 * wordW + 3 * regAw;
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Generic two-entry valid/ready pipeline buffer on an opaque packed payload.
// With SKID=1 the upstream ready is a register: a second (skid) entry absorbs
// the one transfer that can arrive in the cycle the downstream stalls, so no
// combinational path runs from outReady to inReady. With SKID=0 it is a plain
// single-entry register whose ready is ~outValid | outReady.
// A synchronous flush empties the buffer and discards any same-cycle input;
// payload registers keep their contents across a flush.
//
// Ports
//   clk       clock, all state changes on posedge
//   clr       synchronous active-high reset, dominates everything
//   flush     synchronous kill of all held entries
//   inValid   upstream offers inData
//   inReady   buffer can accept (transfer when inValid & inReady)
//   inData    packed payload from upstream
//   outValid  head entry valid
//   outReady  downstream consumes (transfer when outValid & outReady)
//   outData   payload of the head entry, holds last value when invalid
// ---------------------------------------------------------------------------
module pipe_skid_buf
   import idex_pipe_stage_pkg::*;
#(
   parameter int W    = 8,
   parameter int SKID = 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         flush,
   input  logic         inValid,
   output logic         inReady,
   input  logic [W-1:0] inData,
   output logic         outValid,
   input  logic         outReady,
   output logic [W-1:0] outData
);

   skidState_t   state;
   skidState_t   stateNext;
   logic [W-1:0] mainQ;
   logic [W-1:0] skidQ;
   logic         readyQ;
   logic         acceptIn;
   logic         takeOut;
   logic         loadMainIn;
   logic         loadMainSkid;
   logic         loadSkid;

   // The head entry is always the main register; any non-empty state means
   // there is something for the downstream stage to look at.
   assign outValid = (state != ST_EMPTY);
   assign outData  = mainQ;

   // In skid mode the ready seen upstream comes straight from a flop. In
   // single-entry mode the only way to accept while full is to be emptied in
   // the same cycle, so ready has to look at outReady.
   assign inReady  = (SKID != 0) ? readyQ : (~outValid | outReady);

   assign acceptIn = inValid & inReady;
   assign takeOut  = outValid & outReady;

   // Next-state and load-enable decode. A flush overrides every handshake:
   // the buffer empties and a transfer offered in the same cycle is thrown
   // away, because decode is being flushed too. When the head leaves and a
   // new word arrives together the main entry is simply replaced, so the
   // stream keeps full throughput without a bubble. The skid entry is only
   // filled when a word arrives while the head is stalled, and it moves into
   // main as soon as the head is consumed.
   always_comb begin
      stateNext    = state;
      loadMainIn   = 1'b0;
      loadMainSkid = 1'b0;
      loadSkid     = 1'b0;
      if (flush) begin
         stateNext = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (acceptIn) begin
                  stateNext  = ST_FULL;
                  loadMainIn = 1'b1;
               end
            end
            ST_FULL: begin
               if (acceptIn && takeOut) begin
                  stateNext  = ST_FULL;
                  loadMainIn = 1'b1;
               end else if (acceptIn && (SKID != 0)) begin
                  stateNext = ST_SKID;
                  loadSkid  = 1'b1;
               end else if (takeOut) begin
                  stateNext = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (takeOut) begin
                  stateNext    = ST_FULL;
                  loadMainSkid = 1'b1;
               end
            end
            default: begin
               stateNext = ST_EMPTY;
            end
         endcase
      end
   end

   // State, registered ready and payload storage. Ready is computed from the
   // next state so it is already correct in the cycle the buffer fills up;
   // it drops to 0 for the reset cycle itself and comes up one cycle after
   // clr is released. Payload registers only change on an explicit load, so
   // a stalled or flushed head keeps its bits.
   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= ST_EMPTY;
         readyQ <= 1'b0;
         mainQ  <= '0;
         skidQ  <= '0;
      end else begin
         state  <= stateNext;
         readyQ <= (stateNext != ST_SKID);
         if (loadMainIn) begin
            mainQ <= inData;
         end else if (loadMainSkid) begin
            mainQ <= skidQ;
         end
         if (loadSkid) begin
            skidQ <= inData;
         end
      end
   end

endmodule

// File: rtl/idex_pipe_stage.sv
// ---------------------------------------------------------------------------
// idex_pipe_stage
// Decode->execute pipeline register. Carries one decoded instruction from the
// control unit / register file (D side) to the ALU / forwarding logic (E side)
// with a valid/ready handshake, stall, synchronous flush and an optional
// two-entry skid buffer. Bubbles are explicit: CtrlE reads all zeros whenever
// validE is low, while the data fields keep their last values. Two saturating
// counters report stalled cycles and bubble cycles.
//
// Ports
//   clk, clr                     clock / synchronous active-high reset
//   flushE                       kill every held instruction
//   validD, readyD               decode-side handshake
//   CtrlD, Rd1D, Rd2D            control word and register read data
//   RsD, RtD, RdD, SignImmD      register specifiers and immediate
//   validE, readyE               execute-side handshake (readyE=0 stalls)
//   CtrlE                        control word, masked to 0 when invalid
//   Rd1E, Rd2E, RsE, RtE, RdE,
//   SignImmE                     head-entry payload
//   stallCnt                     cycles with validE & ~readyE, saturating
//   bubbleCnt                    cycles with validE = 0, saturating
// ---------------------------------------------------------------------------
module idex_pipe_stage
   import idex_pipe_stage_pkg::*;
#(
   parameter int size   = 31,
   parameter int REG_AW = 5,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              flushE,
   input  logic              validD,
   output logic              readyD,
   input  logic [CTRL_W-1:0] CtrlD,
   input  logic [size:0]     Rd1D,
   input  logic [size:0]     Rd2D,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic [REG_AW-1:0] RdD,
   input  logic [size:0]     SignImmD,
   output logic              validE,
   input  logic              readyE,
   output logic [CTRL_W-1:0] CtrlE,
   output logic [size:0]     Rd1E,
   output logic [size:0]     Rd2E,
   output logic [REG_AW-1:0] RsE,
   output logic [REG_AW-1:0] RtE,
   output logic [REG_AW-1:0] RdE,
   output logic [size:0]     SignImmE,
   output logic [CNT_W-1:0]  stallCnt,
   output logic [CNT_W-1:0]  bubbleCnt
);

   localparam int              WORD_W  = size + 1;
   localparam int              PW      = payloadWidth(CTRL_W, WORD_W, REG_AW);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [PW-1:0]     payloadD;
   logic [PW-1:0]     payloadE;
   logic [CTRL_W-1:0] ctrlHeld;

   // The whole instruction travels as one opaque word so the buffer stays
   // reusable for the later pipeline registers; order is control first,
   // then the two read values, the three specifiers and the immediate.
   assign payloadD = {CtrlD, Rd1D, Rd2D, RsD, RtD, RdD, SignImmD};

   pipe_skid_buf #(
      .W    (PW),
      .SKID (SKID)
   ) skidBuf (
      .clk      (clk),
      .clr      (clr),
      .flush    (flushE),
      .inValid  (validD),
      .inReady  (readyD),
      .inData   (payloadD),
      .outValid (validE),
      .outReady (readyE),
      .outData  (payloadE)
   );

   assign {ctrlHeld, Rd1E, Rd2E, RsE, RtE, RdE, SignImmE} = payloadE;

   // A bubble must never write a register or memory, so the control word is
   // gated by validE. The data fields are left alone to avoid needless
   // toggling on the forwarding muxes.
   assign CtrlE = ctrlHeld & {CTRL_W{validE}};

   // Performance counters. A stall is a cycle where execute holds a valid
   // instruction but refuses it; a bubble is any cycle with nothing valid,
   // flushed cycles included. Both stick at all-ones and only clr clears
   // them, so software can read them at leisure without wrap ambiguity.
   always_ff @(posedge clk) begin
      if (clr) begin
         stallCnt  <= '0;
         bubbleCnt <= '0;
      end else begin
         if (validE && !readyE && (stallCnt != CNT_MAX)) begin
            stallCnt <= stallCnt + CNT_ONE;
         end
         if (!validE && (bubbleCnt != CNT_MAX)) begin
            bubbleCnt <= bubbleCnt + CNT_ONE;
         end
      end
   end

endmodule
